program_counter_unit: RTL
=========================

// Module: program_counter_unit
// PURPOSE
// - Fetch-side PC generator; sits directly upstream of instruction_memory and drives its 64-bit pc input.
// - Sequences PC = RESET_PC, +4, ...; honours stall and taken-branch redirects; halts at program end.
// - Flags when instruction_memory's registered output (1-cycle latency) holds a valid instruction.
// PARAMETERS
// - RESET_PC    64'h0   PC loaded on reset; multiple of 4.
// - PROG_END    64'd48  first byte address past the program; PC >= PROG_END => halt.
// - IMEM_BYTES  64      instruction memory size in bytes; PROG_END <= IMEM_BYTES, both multiples of 4.
// PORTS
// - clk            in   1   system clock; all state updates on rising edge.
// - reset          in   1   asynchronous, active-high reset.
// - stall          in   1   hold PC this cycle; wins over branch_taken.
// - branch_taken   in   1   redirect the next PC to branch_target.
// - branch_target  in   64  redirect address; sampled only when branch_taken=1 and stall=0.
// - pc             out  64  current PC; connect to instruction_memory.pc.
// - pc_valid       out  1   pc is a live fetch address this cycle.
// - instr_valid    out  1   instruction_memory.instruction is valid this cycle (pc_valid delayed 1 clk).
// - halted         out  1   sticky; PC generation stopped.
// - misalign_err   out  1   sticky; misaligned redirect trapped (MISALIGN_TRAP_EN only, else tied 0).
// - fetch_count    out  32  number of PCs issued, saturating.
// BEHAVIOUR
// - Reset (async, any time, incl. mid-run): state=IDLE, pc=RESET_PC, pc_valid=0, instr_valid=0,
//   halted=0, misalign_err=0, fetch_count=0. Outputs are all registered and take effect immediately.
// - FSM states:
//   - IDLE: first edge after reset deassert -> RUN. pc unchanged.
//   - RUN: PC stepping, per edge rules below.
//   - HALT: absorbing; left only by reset.
// - pc_valid = (state==RUN) && (pc < PROG_END); combinational from registered state/pc.
// - instr_valid <= pc_valid each edge, regardless of stall. While stalled the memory re-latches the same word.
// - RUN, per edge:
//   - stall=1: pc, fetch_count hold; branch ignored.
//   - else if pc >= PROG_END: -> HALT, halted=1, pc holds.
//   - else: fetch_count += 1, saturating at 32'hFFFF_FFFF.
//     - Next pc = branch_taken ? branch_target : pc + 64'd4.
//     - Arithmetic is 64-bit, wraps modulo 2^64.
// - Redirect to an address >= PROG_END is legal: pc takes it, pc_valid=0 next cycle, HALT the following edge.
// - PC equal to PROG_END-4 issues normally; pc == PROG_END halts on the next unstalled edge.
// - In HALT: pc frozen, pc_valid=0, instr_valid falls 1 cycle after entry, fetch_count frozen.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined:
//   - Redirect with branch_target[1:0] != 0 (unstalled) is not taken; pc holds.
//   - State -> HALT with halted=1 and misalign_err=1 on that edge; fetch_count does not increment.
// - MISALIGN_TRAP_EN undefined:
//   - Redirect uses {branch_target[63:2], 2'b00}; misalign_err is constant 0.
// TESTING
// - T1 Reset release, no stall or branch:
//   - pc = 0x00 in IDLE, then 0x00, 0x04 .. 0x2C in RUN; instr_valid trails pc_valid by 1 clk.
//   - At pc = 0x30 pc_valid=0, halted=1 next edge, fetch_count = 12.
// - T2 stall=1 for 3 cycles while pc = 0x08:
//   - pc stays 0x08 and fetch_count stays 2 during the stall; pc = 0x0C on the first unstalled edge.
// - T3 branch_taken=1, target=0x20 at pc = 0x0C: next pc = 0x20.
//   - Same with stall=1 as well: pc holds 0x0C and the branch is dropped.
// - T4 branch_taken=1, target=0x22 at pc = 0x0C:
//   - MISALIGN_TRAP_EN: pc=0x0C, halted=1, misalign_err=1.
//   - Without the macro: pc=0x20, misalign_err=0.
// - T5 reset pulsed asynchronously mid-clock at pc = 0x14:
//   - pc=0x00 and all flags/count clear immediately; the T1 sequence replays after release.
// - T6 branch_taken=1, target=0x40 at pc = 0x04:
//   - pc=0x40, pc_valid=0, halted=1 one edge later, instr_valid=0 thereafter.

Source files
------------

// File: rtl/program_counter_unit.sv
// program_counter_unit: fetch-side PC generator feeding instruction_memory (1-cycle read latency).
// Define MISALIGN_TRAP_EN to trap misaligned redirects instead of masking them to word alignment.
//
// state | meaning
// IDLE  | first cycle after reset, pc = RESET_PC, nothing issued
// RUN   | issuing pc on every unstalled edge
// HALT  | program end or trap reached; left only by reset
module program_counter_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] PROG_END   = 64'd48,
  parameter int unsigned IMEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] pc,
  output logic        pc_valid,
  output logic        instr_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Never fetch past the memory, even if PROG_END were set beyond it.
  localparam logic [63:0] FETCH_LIMIT =
    (PROG_END < 64'(IMEM_BYTES)) ? PROG_END : 64'(IMEM_BYTES);

  state_t      state, state_nxt;
  logic [63:0] pc_nxt;
  logic        halted_nxt;
  logic        misalign_err_nxt;
  logic [31:0] fetch_count_nxt;
  logic        misalign;
  logic [63:0] redirect_pc;

`ifdef MISALIGN_TRAP_EN
  assign misalign    = (branch_target[1:0] != 2'b00);
  assign redirect_pc = branch_target;
`else
  assign misalign    = 1'b0;
  assign redirect_pc = branch_target & ~64'd3;
`endif

  assign pc_valid = (state == RUN) && (pc < FETCH_LIMIT);

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    halted_nxt       = halted;
    misalign_err_nxt = misalign_err;
    fetch_count_nxt  = fetch_count;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (!stall) begin
          if (pc >= FETCH_LIMIT) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
          end else if (branch_taken && misalign) begin
            state_nxt        = HALT;
            halted_nxt       = 1'b1;
            misalign_err_nxt = 1'b1;
          end else begin
            if (fetch_count != 32'hFFFF_FFFF) fetch_count_nxt = fetch_count + 32'd1;
            pc_nxt = branch_taken ? redirect_pc : pc + 64'd4;
          end
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr_valid  <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      instr_valid  <= pc_valid;
      halted       <= halted_nxt;
      misalign_err <= misalign_err_nxt;
      fetch_count  <= fetch_count_nxt;
    end
  end

endmodule
